// File: rtl/shift165_pkg.sv
// shift165_pkg: state encoding and counter-width helpers shared by
// the 74x165 chain reader and its phase timer.
package shift165_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_SLO,
        ST_SHI,
        ST_DONE
    } state_e;

    // Default geometry, for reference by users of the block.
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_NDEV   = 1;
    localparam int DEF_CLKDIV = 4;

    // Bits needed to hold the value maxval (bit and phase counters).
    function automatic int cnt_w(input int maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int DEF_BIT_W   = cnt_w(DEF_WIDTH * DEF_NDEV);
    localparam int DEF_PHASE_W = cnt_w(DEF_CLKDIV);

endpackage

// File: rtl/shift165_phase_timer.sv
// shift165_phase_timer: loadable down-counter; tick_o is high on the
// last cycle of a loaded phase. Ports: clk, rst, load_i, load_val_i, tick_o.
module shift165_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A phase of length L is loaded with L; count L..1, tick on 1.
    assign tick_o = (cnt_q == W'(1));

endmodule

// File: rtl/shift165_reader.sv
// shift165_reader: drives shld/serclk of a 74x165 chain, assembles the
// serial word from q7 and offers it on a valid/ready port.
// Ports: clk, rst, start, shld, serclk, q7, data[N-1:0], valid, ready,
// busy; overrun only when SHIFT165_READER_AUTOSCAN_EN is defined
// (continuous scanning, start ignored, sticky overrun on a dropped word).
module shift165_reader
    import shift165_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int NDEV        = 1,
    parameter int CLKDIV      = 4,
    parameter int LOAD_CYCLES = 2,
    parameter int SETTLE      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  shld,
    output logic                  serclk,
    input  logic                  q7,
    output logic [WIDTH*NDEV-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  busy
`ifdef SHIFT165_READER_AUTOSCAN_EN
    ,
    output logic                  overrun
`endif
);

    localparam int N  = WIDTH * NDEV;
    localparam int BW = cnt_w(N);
    localparam int TW = cnt_w(max3(CLKDIV, LOAD_CYCLES, SETTLE));

    localparam logic [TW-1:0] LOAD_V = TW'(LOAD_CYCLES);
    localparam logic [TW-1:0] SETL_V = TW'(SETTLE);
    localparam logic [TW-1:0] DIV_V  = TW'(CLKDIV);
    localparam logic [BW-1:0] LAST_B = BW'(N - 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [N-1:0]    sh_q, sh_d;
    logic [N-1:0]    data_q, data_d;
    logic            valid_q, valid_d;
    logic            shld_q, shld_d;
    logic            serclk_q, serclk_d;
    logic            t_load;
    logic [TW-1:0]   t_val;
    logic            t_tick;

`ifdef SHIFT165_READER_AUTOSCAN_EN
    logic            overrun_q, overrun_d;
    logic            unused_start;
    assign unused_start = start;
`endif

    shift165_phase_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (t_load),
        .load_val_i (t_val),
        .tick_o     (t_tick)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = valid_q;
        t_load  = 1'b0;
        t_val   = '0;
`ifdef SHIFT165_READER_AUTOSCAN_EN
        overrun_d = overrun_q;
`endif
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
`ifdef SHIFT165_READER_AUTOSCAN_EN
                state_d = ST_LOAD;
                t_load  = 1'b1;
                t_val   = LOAD_V;
                bit_d   = '0;
`else
                // A word the consumer has not taken blocks a new scan.
                if (start && !(valid_q && !ready)) begin
                    state_d = ST_LOAD;
                    t_load  = 1'b1;
                    t_val   = LOAD_V;
                    bit_d   = '0;
                end
`endif
            end
            ST_LOAD: begin
                if (t_tick) begin
                    state_d = ST_SETTLE;
                    t_load  = 1'b1;
                    t_val   = SETL_V;
                end
            end
            ST_SETTLE: begin
                if (t_tick) begin
                    state_d = ST_SLO;
                    t_load  = 1'b1;
                    t_val   = DIV_V;
                end
            end
            ST_SLO: begin
                if (t_tick) begin
                    sh_d  = (sh_q << 1) | N'(q7);
                    bit_d = bit_q + BW'(1);
                    if (bit_q == LAST_B) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHI;
                        t_load  = 1'b1;
                        t_val   = DIV_V;
                    end
                end
            end
            ST_SHI: begin
                if (t_tick) begin
                    state_d = ST_SLO;
                    t_load  = 1'b1;
                    t_val   = DIV_V;
                end
            end
            ST_DONE: begin
`ifdef SHIFT165_READER_AUTOSCAN_EN
                if (valid_q && !ready) begin
                    overrun_d = 1'b1;
                end else begin
                    data_d  = sh_q;
                    valid_d = 1'b1;
                end
                state_d = ST_LOAD;
                t_load  = 1'b1;
                t_val   = LOAD_V;
                bit_d   = '0;
`else
                // New word wins over a same-cycle handshake.
                data_d  = sh_q;
                valid_d = 1'b1;
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pins follow the next state so they change on the transition edge;
    // SHI never overlaps LOAD, so serclk cannot rise while shld is low.
    assign shld_d   = (state_d != ST_LOAD);
    assign serclk_d = (state_d == ST_SHI);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            bit_q    <= '0;
            sh_q     <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            shld_q   <= 1'b1;
            serclk_q <= 1'b0;
`ifdef SHIFT165_READER_AUTOSCAN_EN
            overrun_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            shld_q   <= shld_d;
            serclk_q <= serclk_d;
`ifdef SHIFT165_READER_AUTOSCAN_EN
            overrun_q <= overrun_d;
`endif
        end
    end

    assign shld   = shld_q;
    assign serclk = serclk_q;
    assign data   = data_q;
    assign valid  = valid_q;
    assign busy   = (state_q != ST_IDLE);
`ifdef SHIFT165_READER_AUTOSCAN_EN
    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_shift165_reader.sv
// tb_shift165_reader: pairs two reader configurations with behavioural
// 74x165 chains and checks words, latency, serclk edges and corner cases.
`timescale 1ns/1ps
module tb_shift165_reader;

    localparam int N1 = 8;
    localparam int L1 = 2;
    localparam int S1 = 3;
    localparam int C1 = 4;
    localparam int N2 = 16;
    localparam int L2 = 1;
    localparam int S2 = 2;
    localparam int C2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start1, ready1, shld1, serclk1, q71, valid1, busy1;
    logic [N1-1:0] data1;
    logic start2, ready2, shld2, serclk2, q72, valid2, busy2;
    logic [N2-1:0] data2;
`ifdef SHIFT165_READER_AUTOSCAN_EN
    logic ovr1, ovr2;
`endif

    shift165_reader #(
        .WIDTH(8), .NDEV(1), .CLKDIV(C1), .LOAD_CYCLES(L1), .SETTLE(S1)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .shld(shld1),
        .serclk(serclk1), .q7(q71), .data(data1), .valid(valid1),
        .ready(ready1), .busy(busy1)
`ifdef SHIFT165_READER_AUTOSCAN_EN
        , .overrun(ovr1)
`endif
    );

    shift165_reader #(
        .WIDTH(8), .NDEV(2), .CLKDIV(C2), .LOAD_CYCLES(L2), .SETTLE(S2)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .shld(shld2),
        .serclk(serclk2), .q7(q72), .data(data2), .valid(valid2),
        .ready(ready2), .busy(busy2)
`ifdef SHIFT165_READER_AUTOSCAN_EN
        , .overrun(ovr2)
`endif
    );

    // 165 chain models: shld seen two clocks late, shift on serclk rise.
    logic [N1-1:0] par1, sr1 = '0;
    logic [N2-1:0] par2, sr2 = '0;
    logic a1 = 1'b1, a2 = 1'b1, ap = 1'b0;
    logic b1 = 1'b1, b2 = 1'b1, bp = 1'b0;

    always @(posedge clk) begin
        a1 <= shld1; a2 <= a1; ap <= serclk1;
        if (!a2) sr1 <= par1;
        else if (serclk1 && !ap) sr1 <= sr1 << 1;
        b1 <= shld2; b2 <= b1; bp <= serclk2;
        if (!b2) sr2 <= par2;
        else if (serclk2 && !bp) sr2 <= sr2 << 1;
    end
    assign q71 = sr1[N1-1];
    assign q72 = sr2[N2-1];

    int rises1 = 0, rises2 = 0, bad = 0;
    logic m1 = 1'b0, m2 = 1'b0;
    always @(negedge clk) begin
        if (serclk1 === 1'b1 && !m1) rises1 <= rises1 + 1;
        if (serclk2 === 1'b1 && !m2) rises2 <= rises2 + 1;
        m1 <= (serclk1 === 1'b1);
        m2 <= (serclk2 === 1'b1);
        bad <= bad + int'(serclk1 === 1'b1 && shld1 === 1'b0)
                   + int'(serclk2 === 1'b1 && shld2 === 1'b0);
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles from the start-accept edge until valid is seen high.
    function automatic int exp_lat(input int l, input int s, input int c,
                                   input int n);
        return l + s + (2 * n - 1) * c + 1;
    endfunction

    task automatic wait_v1(output int n);
        n = 0;
        while (valid1 !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic scan1(input logic [N1-1:0] p, input string nm);
        int n, r0;
        par1 = p;
        r0 = rises1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk({nm, "_busy"}, 32'(busy1), 1);
        wait_v1(n);
        chk({nm, "_lat"}, n, exp_lat(L1, S1, C1, N1));
        chk({nm, "_data"}, 32'(data1), 32'(p));
        chk({nm, "_rises"}, rises1 - r0, N1 - 1);
        chk({nm, "_idle"}, 32'(busy1), 0);
    endtask

    task automatic scan2(input logic [N2-1:0] p, input string nm);
        int n, r0;
        par2 = p;
        r0 = rises2;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (valid2 !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk({nm, "_lat"}, n, exp_lat(L2, S2, C2, N2));
        chk({nm, "_data"}, 32'(data2), 32'(p));
        chk({nm, "_rises"}, rises2 - r0, N2 - 1);
        chk({nm, "_idle"}, 32'(busy2), 0);
    endtask

    typedef struct {
        logic [N1-1:0] par;
        logic [N1-1:0] exp;
    } vec_t;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   n, r0;
        logic [N1-1:0] rv;
        logic [N2-1:0] rv2;

        tbl[0] = '{8'hA5, 8'hA5};
        tbl[1] = '{8'h00, 8'h00};
        tbl[2] = '{8'hFF, 8'hFF};
        tbl[3] = '{8'h80, 8'h80};
        tbl[4] = '{8'h01, 8'h01};
        tbl[5] = '{8'h5A, 8'h5A};

        rst = 1'b1;
        start1 = 1'b0; ready1 = 1'b1; par1 = 8'h5A;
        start2 = 1'b0; ready2 = 1'b1; par2 = 16'h0;
        repeat (3) tick();

        chk("rst_shld", 32'(shld1), 1);
        chk("rst_serclk", 32'(serclk1), 0);
        chk("rst_valid", 32'(valid1), 0);
        chk("rst_data", 32'(data1), 0);
        chk("rst_busy", 32'(busy1), 0);

`ifdef SHIFT165_READER_AUTOSCAN_EN
        ready1 = 1'b0;
        ready2 = 1'b0;
        rst = 1'b0;
        r0 = rises1;
        repeat (1 + exp_lat(L1, S1, C1, N1)) tick();
        chk("auto_valid1", 32'(valid1), 1);
        chk("auto_data1", 32'(data1), 32'h5A);
        chk("auto_rises1", rises1 - r0, N1 - 1);
        chk("auto_ovr0", 32'(ovr1), 0);
        par1 = 8'hE7;
        repeat (exp_lat(L1, S1, C1, N1)) tick();
        chk("auto_held", 32'(data1), 32'h5A);
        chk("auto_ovr1", 32'(ovr1), 1);
        chk("auto_busy", 32'(busy1), 1);
        repeat (exp_lat(L1, S1, C1, N1) - 1) tick();
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        chk("auto_hs_valid", 32'(valid1), 1);
        chk("auto_hs_data", 32'(data1), 32'hE7);
        chk("auto_ovr_sticky", 32'(ovr1), 1);
        chk("auto_activity", 32'(rises1 - r0 >= 3 * (N1 - 1)), 1);
`else
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            scan1(tbl[i].par, "tbl");
            chk("tbl_exp", 32'(data1), 32'(tbl[i].exp));
        end

        scan2(16'h3C81, "chain2");
        for (int i = 0; i < 3; i++) begin
            rv2 = 16'($urandom);
            scan2(rv2, "rnd2");
        end

        // Unconsumed word blocks start; data must stay put.
        ready1 = 1'b0;
        scan1(8'h3C, "hold_first");
        tick();
        chk("hold_valid", 32'(valid1), 1);
        par1 = 8'hC3;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (3) tick();
        chk("hold_busy", 32'(busy1), 0);
        chk("hold_data", 32'(data1), 32'h3C);
        chk("hold_valid2", 32'(valid1), 1);
        ready1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("hold_hs_valid", 32'(valid1), 0);
        chk("hold_busy2", 32'(busy1), 1);
        wait_v1(n);
        chk("hold_lat", n, exp_lat(L1, S1, C1, N1));
        chk("hold_new", 32'(data1), 32'hC3);

        // Reset on the edge of the 4th sample.
        tick();
        par1 = 8'h96;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (L1 + S1 + 7 * C1 - 1) tick();
        rst = 1'b1;
        tick();
        chk("mid_shld", 32'(shld1), 1);
        chk("mid_serclk", 32'(serclk1), 0);
        chk("mid_valid", 32'(valid1), 0);
        chk("mid_data", 32'(data1), 0);
        chk("mid_busy", 32'(busy1), 0);
        rst = 1'b0;
        tick();
        scan1(8'h96, "post_rst");

        for (int i = 0; i < 10; i++) begin
            rv = 8'($urandom);
            scan1(rv, "rnd1");
        end

        chk("no_rise_in_load", bad, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
